// File: rtl/sad_pkg.sv
// sad_pkg
// Shared widths and result type for the 5-pair, 1-bit-element SAD unit.
//   SAD_PAIRS  : number of element pairs compared
//   SAD_ELEM_W : width of one operand element
//   SAD_OUT_W  : width of the SAD result (holds 0..5)
//   sad_t      : unsigned SAD result type
`timescale 1ns/1ps
package sad_pkg;

  localparam int SAD_PAIRS  = 5;
  localparam int SAD_ELEM_W = 1;
  localparam int SAD_OUT_W  = 3;

  typedef logic [SAD_OUT_W-1:0] sad_t;

endpackage : sad_pkg

// File: rtl/sad_popcount5.sv
// sad_popcount5
// Counts the set bits of a 5-bit difference vector using adder compression:
// two full adders reduce the five weight-1 bits to one weight-1 bit and two
// weight-2 carries, and a half adder merges the carries into weights 2 and 4.
// Ports:
//   diff_i  input  [4:0]  per-element difference bits
//   cnt_o   output [2:0]  number of set bits, 0..5
`timescale 1ns/1ps
module sad_popcount5
  import sad_pkg::*;
(
  input  logic [SAD_PAIRS-1:0] diff_i,
  output sad_t                 cnt_o
);

  logic s0;
  logic c0;
  logic s1;
  logic c1;

  always_comb begin
    // First full adder: bits 0..2.
    s0 = diff_i[0] ^ diff_i[1] ^ diff_i[2];
    c0 = (diff_i[0] & diff_i[1]) | (diff_i[2] & (diff_i[0] ^ diff_i[1]));
    // Second full adder: partial sum plus bits 3..4.
    s1 = s0 ^ diff_i[3] ^ diff_i[4];
    c1 = (s0 & diff_i[3]) | (diff_i[4] & (s0 ^ diff_i[3]));
    // Half adder on the two weight-2 carries; their sum never exceeds 2,
    // so the total stays within 0..5.
    cnt_o = {c0 & c1, c0 ^ c1, s1};
  end

endmodule : sad_popcount5

// File: rtl/sad_i10_o3.sv
// sad_i10_o3
// Registered sum of absolute differences over five 1-bit element pairs.
// For 1-bit operands |a - b| equals a ^ b, so the SAD is the popcount of
// A ^ B, registered once. One new result every cycle, latency 1.
// Ports:
//   pi0..pi4  input   operand A elements a0..a4
//   pi5..pi9  input   operand B elements b0..b4
//   po0..po2  output  registered SAD, po0 = LSB, range 0..5
//   clk       input   rising-edge clock
//   rst       input   asynchronous active-high reset, clears po
`timescale 1ns/1ps
module sad_i10_o3
  import sad_pkg::*;
(
  input  logic pi0,
  input  logic pi1,
  input  logic pi2,
  input  logic pi3,
  input  logic pi4,
  input  logic pi5,
  input  logic pi6,
  input  logic pi7,
  input  logic pi8,
  input  logic pi9,
  output logic po0,
  output logic po1,
  output logic po2,
  input  logic clk,
  input  logic rst
);

  logic [SAD_PAIRS-1:0] a_p0;
  logic [SAD_PAIRS-1:0] b_p0;
  logic [SAD_PAIRS-1:0] diff_p0;
  sad_t                 sad_d;
  sad_t                 sad_p1_q;

  // ---- Stage p0: combinational difference and count ----
  always_comb begin
    a_p0    = {pi4, pi3, pi2, pi1, pi0};
    b_p0    = {pi9, pi8, pi7, pi6, pi5};
    diff_p0 = a_p0 ^ b_p0;
  end

  sad_popcount5 u_popcount (
    .diff_i (diff_p0),
    .cnt_o  (sad_d)
  );

  // ---- Stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_p1_q <= '0;
    end else begin
      sad_p1_q <= sad_d;
    end
  end

  assign po0 = sad_p1_q[0];
  assign po1 = sad_p1_q[1];
  assign po2 = sad_p1_q[2];

endmodule : sad_i10_o3

// File: tb/tb_sad_i10_o3.sv
`timescale 1ns/1ps
module tb_sad_i10_o3;

  logic       clk;
  logic       rst;
  logic [9:0] pi;
  logic       po0;
  logic       po1;
  logic       po2;
  logic [2:0] po;

  int checks;
  int errors;

  assign po = {po2, po1, po0};

  sad_i10_o3 dut (
    .pi0 (pi[0]),
    .pi1 (pi[1]),
    .pi2 (pi[2]),
    .pi3 (pi[3]),
    .pi4 (pi[4]),
    .pi5 (pi[5]),
    .pi6 (pi[6]),
    .pi7 (pi[7]),
    .pi8 (pi[8]),
    .pi9 (pi[9]),
    .po0 (po0),
    .po1 (po1),
    .po2 (po2),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] exp);
    checks++;
    assert (po === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, po, exp);
    end
  endtask

  // Apply a vector at the falling edge, then check the result 1 ns after
  // the next rising edge.
  task automatic apply_check(input logic [9:0] v, input string tag, input logic [2:0] exp);
    @(negedge clk);
    pi = v;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  function automatic logic [2:0] ref_sad(input logic [9:0] v);
    logic [4:0] d;
    logic [2:0] n;
    d = v[4:0] ^ v[9:5];
    n = 3'd0;
    for (int k = 0; k < 5; k++) n = n + {2'b00, d[k]};
    return n;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    pi     = 10'b0000011111;

    // Reset takes effect before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 3'b000);
    @(posedge clk);
    #1;
    check("reset_held", 3'b000);

    // Release with A=10101, B=10110.
    @(negedge clk);
    rst = 1'b0;
    pi  = 10'b1011010101;
    @(posedge clk);
    #1;
    check("reset_release", 3'b010);

    // Equal operands.
    apply_check(10'b1111111111, "equal_ones", 3'b000);
    apply_check(10'b0000000000, "equal_zeros", 3'b000);

    // Maximum.
    apply_check(10'b0000011111, "max_a", 3'b101);
    apply_check(10'b1111100000, "max_b", 3'b101);

    // Single and double differences.
    apply_check(10'b1111111110, "single_diff", 3'b001);
    apply_check(10'b0000110000, "double_diff_a", 3'b010);
    apply_check(10'b1000000001, "double_diff_b", 3'b010);

    // Streaming: value must hold until the next edge, then update.
    apply_check(10'b0000011111, "stream0", 3'b101);
    @(negedge clk);
    pi = 10'b1111111111;
    #1;
    check("stream_hold0", 3'b101);
    @(posedge clk);
    #1;
    check("stream1", 3'b000);
    @(negedge clk);
    pi = 10'b0000110000;
    #1;
    check("stream_hold1", 3'b000);
    @(posedge clk);
    #1;
    check("stream2", 3'b010);

    // Exhaustive sweep with a reset in the middle.
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = i[9:0];
      apply_check(v, "sweep", ref_sad(v));
      if (i == 512) begin
        #2;
        rst = 1'b1;
        #1;
        check("sweep_reset_async", 3'b000);
        @(posedge clk);
        #1;
        check("sweep_reset_held", 3'b000);
        @(negedge clk);
        rst = 1'b0;
        pi  = 10'b1110000001;
        @(posedge clk);
        #1;
        check("sweep_resume", 3'b100);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sad_i10_o3

// File: doc/sad_i10_o3.md
# sad_i10_o3

Registered 5-element sum-of-absolute-differences (SAD) unit over 1-bit operands. It compares two 5-bit vectors A and B element by element and outputs the count of differing positions, 0..5, on a 3-bit bus. It is a leaf datapath block in the error-evaluation benchmark set. It is the clocked reference implementation that approximate variants are compared against.

## Interface
- No parameters. Widths are fixed: 5 element pairs, 1-bit elements, 3-bit result.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- pi0..pi4  input  1 each  operand A elements a0..a4 (pi0 = a0)
- pi5..pi9  input  1 each  operand B elements b0..b4 (pi5 = b0)
- po0..po2  output  1 each  registered SAD result, po0 = LSB
- Declaration order: pi0..pi9, po0..po2, clk, rst. Existing positional instantiations of the 13 data ports stay valid.

## Operation
- Element pairs: (a_i, b_i) = (pi[i], pi[i+5]) for i = 0..4, where pi[9:0] = {pi9..pi0}.
- Per element: d_i = |a_i − b_i|, which is identical to a_i XOR b_i.
- SAD = d0 + d1 + d2 + d3 + d4. The range is 0..5. It is unsigned and always fits 3 bits, with no overflow or saturation case.
- {po2,po1,po0} = SAD registered.
- Values 6 and 7 never appear on the outputs.
- The block has no enable and no handshake. A new sample is taken on every clock edge.
- Inputs are purely combinational into the register. There is no input register.

## Timing
- Latency is 1 cycle. The SAD of the inputs present at rising edge k appears on po after edge k and holds until edge k+1.
- Throughput is one result per cycle.
- Reset: when rst is asserted, po = 3'b000 immediately, without waiting for a clock edge. po stays 000 while rst is high.
- First edge with rst low: po loads the SAD of the current inputs.
- Reset asserted mid-stream discards the in-flight result. No state survives the reset.
- The inputs must meet setup and hold to clk. There is no input synchronisation inside the block.
- The combinational path is 5 XORs plus a 5-input popcount, so it fits a single cycle.

## Structure
- Shared package sad_pkg holds:
  - SAD_PAIRS = 5
  - SAD_ELEM_W = 1
  - SAD_OUT_W = 3
  - a typedef for the 3-bit result
- One natural sub-module is sad_popcount5. It takes the 5-bit difference vector and returns a 3-bit count, built as full adder plus half adder compression.
- The top level instantiates sad_popcount5, adds the XOR stage, and adds the reset-able output register.

## Test plan
- Reset: assert rst with arbitrary pi. Required: po = 000 asynchronously. Release rst with pi = 10'b1011010101 (A=10101, B=10110). Required: po = 010 after the next edge.
- Equal operands: pi = 10'b1111111111, then 10'b0000000000. Required: po = 000 for both, each one cycle after it is applied.
- Maximum value: pi = 10'b0000011111 (A=11111, B=00000). Required: po = 101. Then pi = 10'b1111100000. Required: po = 101.
- Single and double differences:
  - pi = 10'b1111111110 → 001
  - pi = 10'b0000110000 → 010
  - pi = 10'b1000000001 → 010
- Latency and streaming: apply 10'b0000011111, 10'b1111111111, 10'b0000110000 on consecutive cycles. Required: po = 101, 000, 010 on the following consecutive cycles.
- Exhaustive: sweep all 1024 pi values. Check po against popcount(pi[4:0] ^ pi[9:5]) with 1-cycle delay. Assert rst mid-sweep and check po = 000 during reset and correct results resuming on the first edge after release.
